cla_seq_wide_adder: RTL and testbench

- Multi-cycle sequencer that performs a W = NBIT*NCHUNK bit addition using one instance of the NBIT-bit gen_cla_decomposed adder.
- Processes one NBIT chunk per clock, least-significant chunk first, and registers the carry between chunks.
- Sits between a requester and a result consumer, with valid/ready handshakes on both sides.
- Lets wide additions reuse the small decomposed CLA instead of building a W-bit CLA.

---
 rtl/cla_seq_wide_adder.sv | 135 +++++++++++++
 tb/tb_cla_seq_wide_adder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_wide_adder.sv
// Wide adder that walks NBIT-bit chunks through one decomposed carry-lookahead
// adder, LSB chunk first, with valid/ready handshakes on both sides.

module gen_cla_decomposed #(
    parameter int unsigned NBIT = 7
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c_in,
    output logic [NBIT:0]   s
);
    logic [NBIT-1:0] g;
    logic [NBIT-1:0] p;
    logic [NBIT:0]   c;
    logic            acc;
    logic            term;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum-of-products of generate/propagate terms, not a ripple chain.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = c_in;
        for (int i = 0; i < int'(NBIT); i++) begin
            acc = c_in;
            for (int k = 0; k <= i; k++) acc = acc & p[k];
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                acc = acc | term;
            end
            c[i+1] = acc;
        end
    end

    assign s = {c[NBIT], p ^ c[NBIT-1:0]};
endmodule

module cla_seq_wide_adder #(
    parameter int unsigned NBIT   = 7,
    parameter int unsigned NCHUNK = 4,
    localparam int unsigned W     = NBIT * NCHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         busy
);
    localparam int unsigned CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NBIT:0]   chunk_s;
    logic [W-1:0]    sum_shift;
    logic            last_chunk;

    gen_cla_decomposed #(.NBIT(NBIT)) u_cla (
        .a    (op_a[NBIT-1:0]),
        .b    (op_b[NBIT-1:0]),
        .c_in (carry_q),
        .s    (chunk_s)
    );

    assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));
    // New chunk enters at the top so the LSB chunk ends up at the bottom after NCHUNK shifts.
    assign sum_shift  = (sum >> NBIT) | (W'(chunk_s[NBIT-1:0]) << (W - NBIT));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand shift registers, inter-chunk carry and result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_a    <= a;
                        op_b    <= b;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    op_a    <= op_a >> NBIT;
                    op_b    <= op_b >> NBIT;
                    sum     <= sum_shift;
                    carry_q <= chunk_s[NBIT];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_chunk) c_out <= chunk_s[NBIT];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_wide_adder.sv
// Directed and streaming checks of cla_seq_wide_adder against a+b+c_in,
// with a queue of expected results filled at acceptance time.

module tb_cla_seq_wide_adder;
    localparam int unsigned NBIT   = 7;
    localparam int unsigned NCHUNK = 4;
    localparam int unsigned W      = NBIT * NCHUNK;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W:0] exp_q[$];

    cla_seq_wide_adder #(.NBIT(NBIT), .NCHUNK(NCHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    // Wait for out_valid within a cycle budget; while waiting the block must look busy.
    task automatic wait_out(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (out_valid !== 1'b1 && n < max_cyc) begin
                check("in_ready_run", 64'(in_ready), 64'd0);
                check("busy_run", 64'(busy), 64'd1);
            end
        end while (out_valid !== 1'b1 && n < max_cyc);
    endtask

    task automatic pop_compare(input string tag, output logic [W:0] e);
        if (exp_q.size() == 0) begin
            e = '0;
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 64'(sum), 64'(e[W-1:0]));
            check({tag, "_cout"}, 64'(c_out), 64'(e[W]));
        end
    endtask

    // Full handshake: accept, scramble inputs, expect result after exactly NCHUNK cycles, acknowledge.
    task automatic run_txn(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int n;
        logic [W:0] e;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = x;
        b = y;
        c_in = ci;
        exp_q.push_back(model(x, y, ci));
        tick();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        c_in = 1'($urandom_range(0, 1));
        wait_out(12, n);
        check({tag, "_latency"}, 64'(n), 64'(NCHUNK));
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        pop_compare(tag, e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_hold_sum"}, 64'(sum), 64'(e[W-1:0]));
    endtask

    initial begin
        int n;
        int last_cyc;
        logic [W:0] e;
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic nc;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(c_out), 64'd0);
        rst = 1'b0;
        tick();

        run_txn("zero", W'(0), W'(0), 1'b0);
        run_txn("chunk_cross", W'(124), W'(15), 1'b0);
        run_txn("wrap_b1", W'('hFFFFFFF), W'(1), 1'b0);
        run_txn("wrap_cin", W'('hFFFFFFF), W'(0), 1'b1);
        run_txn("mixed", W'('h5555555), W'('h2AAAAAA), 1'b1);

        // Stall in DONE while a second request waits on in_valid.
        in_valid = 1'b1;
        a = W'(54);
        b = W'(43);
        c_in = 1'b0;
        exp_q.push_back(model(W'(54), W'(43), 1'b0));
        tick();
        a = W'(2);
        b = W'(3);
        wait_out(12, n);
        check("stall_latency", 64'(n), 64'(NCHUNK));
        pop_compare("stall", e);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_sum", 64'(sum), 64'd97);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_release_ready", 64'(in_ready), 64'd1);
        check("stall_release_sum", 64'(sum), 64'd97);
        exp_q.push_back(model(W'(2), W'(3), 1'b0));
        tick();
        in_valid = 1'b0;
        wait_out(12, n);
        check("second_latency", 64'(n), 64'(NCHUNK));
        pop_compare("second", e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset during the second RUN cycle.
        in_valid = 1'b1;
        a = W'('h5555555);
        b = W'('h2AAAAAA);
        c_in = 1'b1;
        exp_q.push_back(model(a, b, c_in));
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        void'(exp_q.pop_front());
        tick();
        rst = 1'b0;
        tick();
        run_txn("after_abort", W'(6), W'(1), 1'b0);

        // Back-to-back stream with in_valid and out_ready tied high.
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        c_in = 1'($urandom_range(0, 1));
        exp_q.push_back(model(a, b, c_in));
        last_cyc = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i < 49) begin
                na = W'($urandom);
                nb = W'($urandom);
                nc = 1'($urandom_range(0, 1));
                a = na;
                b = nb;
                c_in = nc;
                exp_q.push_back(model(na, nb, nc));
            end else begin
                in_valid = 1'b0;
            end
            wait_out(12, n);
            check("stream_latency", 64'(n), 64'(NCHUNK));
            pop_compare("stream", e);
            if (i > 0) check("stream_spacing", 64'(cyc - last_cyc), 64'(NCHUNK + 2));
            last_cyc = cyc;
            tick();
            check("stream_idle", 64'(in_ready), 64'd1);
        end
        out_ready = 1'b0;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
